// File: rtl/btn_event_decoder.sv
// btn_event_decoder
// Classifies each debounced button press as short or long. While the button
// stays held after a long press, it emits auto-repeat pulses. Hold time is
// counted in 1 ms timebase ticks. All outputs are registered, and each pulse
// lasts exactly one clock.
module btn_event_decoder #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int WIDTH     = $clog2(LONG_MS + 1)
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtn_Level,
  input  logic iTick_1ms,
  output logic oShort,
  output logic oLong,
  output logic oRepeat,
  output logic oHeld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Terminal counter values. The tick that finds the counter here is the
  // LONG_MS-th (or REPEAT_MS-th) tick of the current interval.
  localparam logic [WIDTH-1:0] LONG_LAST   = WIDTH'(LONG_MS - 1);
  localparam logic [WIDTH-1:0] REPEAT_LAST = WIDTH'(REPEAT_MS - 1);
  localparam logic [WIDTH-1:0] COUNT_ONE   = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  // Press classification FSM with registered pulse and level outputs.
  // A release takes priority over a tick in the same cycle.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iBtn_Level) begin
            r_state <= PRESS;
            r_count <= '0;
            r_held  <= 1'b1;
          end
        end
        PRESS: begin
          if (!iBtn_Level) begin
            r_state <= IDLE;
            r_short <= 1'b1;
            r_held  <= 1'b0;
          end else if (iTick_1ms) begin
            if (r_count == LONG_LAST) begin
              r_state <= HOLD;
              r_count <= '0;
              r_long  <= 1'b1;
            end else begin
              r_count <= r_count + COUNT_ONE;
            end
          end
        end
        HOLD: begin
          if (!iBtn_Level) begin
            r_state <= IDLE;
            r_held  <= 1'b0;
          end else if (iTick_1ms) begin
            if (r_count == REPEAT_LAST) begin
              r_count  <= '0;
              r_repeat <= 1'b1;
            end else begin
              r_count <= r_count + COUNT_ONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign oShort  = r_short;
  assign oLong   = r_long;
  assign oRepeat = r_repeat;
  assign oHeld   = r_held;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder
// Randomized, scenario-driven bench for btn_event_decoder. The reference model
// counts ticks since the press began and derives the pulses arithmetically.
module tb_btn_event_decoder;

  localparam int LONG = 4;
  localparam int REP  = 2;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic iBtn_Level = 1'b0;
  logic iTick_1ms = 1'b0;
  logic oShort, oLong, oRepeat, oHeld;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit mInPress = 1'b0;
  int mTicks = 0;
  bit eShort = 1'b0, eLong = 1'b0, eRepeat = 1'b0, eHeld = 1'b0;
  int tickCnt = 0;
  bit randTick = 1'b0;
  bit lastTick = 1'b0;

  btn_event_decoder #(.LONG_MS(LONG), .REPEAT_MS(REP)) dut (
    .iClk(iClk), .iRst(iRst), .iBtn_Level(iBtn_Level), .iTick_1ms(iTick_1ms),
    .oShort(oShort), .oLong(oLong), .oRepeat(oRepeat), .oHeld(oHeld)
  );

  // free-running clock, period 10
  always #5 iClk = ~iClk;

  // Drive one clock of stimulus, advance the model at the edge, then wait
  // 1 time unit so the outputs can be sampled away from the edge.
  task automatic step(input bit btn, input bit rst);
    bit tk;
    tk = randTick ? ($urandom_range(0, 2) == 0) : (tickCnt == 9);
    tickCnt = (tickCnt == 9) ? 0 : tickCnt + 1;
    iBtn_Level = btn;
    iTick_1ms = tk;
    iRst = rst;
    lastTick = tk;
    @(posedge iClk);
    eShort = 1'b0; eLong = 1'b0; eRepeat = 1'b0;
    if (!rst) begin
      mInPress = 1'b0; eHeld = 1'b0;
    end else if (!mInPress) begin
      if (btn) begin mInPress = 1'b1; mTicks = 0; eHeld = 1'b1; end
    end else if (!btn) begin
      eShort = (mTicks < LONG); mInPress = 1'b0; eHeld = 1'b0;
    end else if (tk) begin
      mTicks++;
      if (mTicks == LONG) eLong = 1'b1;
      else if (mTicks > LONG && ((mTicks - LONG) % REP) == 0) eRepeat = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(bit'($urandom_range(0, 1)), 1'b0);
      checks++;
      if ({oShort, oLong, oRepeat, oHeld} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_state: got %b expected 0000", {oShort, oLong, oRepeat, oHeld});
      end
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic test_short_press();
    int shorts = 0, longs = 0;
    for (int c = 0; c < 200 && mTicks < 2 || !mInPress && c == 0; c++) begin
      step(1'b1, 1'b1);
      longs += oLong;
      checks++;
      if ({oShort, oLong, oRepeat, oHeld} !== {eShort, eLong, eRepeat, eHeld}) begin
        failures++;
        $display("[TB] FAIL short_track: got %b expected %b", {oShort, oLong, oRepeat, oHeld}, {eShort, eLong, eRepeat, eHeld});
      end
    end
    step(1'b0, 1'b1);
    checks++;
    if ({oShort, oHeld} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL short_pulse: got short/held %b expected 10", {oShort, oHeld});
    end
    shorts += oShort;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      shorts += oShort; longs += oLong;
    end
    checks++;
    if (shorts != 1 || longs != 0) begin
      failures++;
      $display("[TB] FAIL short_count: got shorts=%0d longs=%0d expected 1/0", shorts, longs);
    end
  endtask

  task automatic test_long_repeat();
    int longs = 0, reps = 0, longAt = -1;
    int repAt[$];
    step(1'b1, 1'b1);
    for (int c = 0; c < 500 && mTicks < 9; c++) begin
      step(1'b1, 1'b1);
      if (oLong) begin longs++; longAt = mTicks; end
      if (oRepeat) begin reps++; repAt.push_back(mTicks); end
      checks++;
      if ({oShort, oLong, oRepeat, oHeld} !== {eShort, eLong, eRepeat, eHeld}) begin
        failures++;
        $display("[TB] FAIL long_track: got %b expected %b", {oShort, oLong, oRepeat, oHeld}, {eShort, eLong, eRepeat, eHeld});
      end
    end
    checks++;
    if (longs != 1 || longAt != 4) begin
      failures++;
      $display("[TB] FAIL long_pulse: got count=%0d at tick %0d expected 1 at tick 4", longs, longAt);
    end
    checks++;
    if (reps != 2 || repAt.size() != 2 || repAt[0] != 6 || repAt[1] != 8) begin
      failures++;
      $display("[TB] FAIL repeat_pulses: got count=%0d expected 2 at ticks 6,8", reps);
    end
    step(1'b0, 1'b1);
    checks++;
    if ({oShort, oLong, oRepeat, oHeld} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL long_release: got %b expected 0000", {oShort, oLong, oRepeat, oHeld});
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_release_on_tick();
    int longs = 0;
    step(1'b1, 1'b1);
    for (int c = 0; c < 200 && !(mTicks == 3 && tickCnt == 9); c++) begin
      step(1'b1, 1'b1);
      longs += oLong;
    end
    step(1'b0, 1'b1);
    checks++;
    if (!lastTick || {oShort, oLong, oHeld} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL release_on_tick: got tick=%b short/long/held=%b expected 1/100", lastTick, {oShort, oLong, oHeld});
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      longs += oLong;
    end
    checks++;
    if (longs != 0) begin
      failures++;
      $display("[TB] FAIL release_on_tick_nolong: got longs=%0d expected 0", longs);
    end
  endtask

  task automatic test_reset_mid_hold();
    int pulses = 0, longAt = -1, postTicks = 0;
    step(1'b1, 1'b1);
    for (int c = 0; c < 500 && mTicks < 5; c++) step(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({oShort, oLong, oRepeat, oHeld} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_mid_hold: got %b expected 0000", {oShort, oLong, oRepeat, oHeld});
      end
    end
    step(1'b1, 1'b1);
    checks++;
    if ({oShort, oHeld} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reenter_press: got short/held %b expected 01", {oShort, oHeld});
    end
    for (int c = 0; c < 200 && longAt < 0; c++) begin
      step(1'b1, 1'b1);
      postTicks += lastTick;
      pulses += oShort + oRepeat;
      if (oLong) longAt = postTicks;
    end
    checks++;
    if (longAt != 4 || pulses != 0) begin
      failures++;
      $display("[TB] FAIL relong_after_reset: got long at tick %0d other=%0d expected 4/0", longAt, pulses);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int shorts = 0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    shorts += oShort;
    checks++;
    if (oShort !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_short: got %b expected 1", oShort);
    end
    step(1'b1, 1'b1);
    checks++;
    if ({oShort, oHeld} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL b2b_repress: got short/held %b expected 01", {oShort, oHeld});
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    shorts += oShort;
    step(1'b0, 1'b1);
    shorts += oShort;
    checks++;
    if (shorts != 2) begin
      failures++;
      $display("[TB] FAIL b2b_count: got shorts=%0d expected 2", shorts);
    end
  endtask

  task automatic test_random();
    bit btn = 1'b0;
    int runLen = 0;
    randTick = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (runLen == 0) begin
        btn = ~btn;
        runLen = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 40));
      end
      runLen--;
      step(btn, ($urandom_range(0, 199) != 0));
      checks++;
      if ({oShort, oLong, oRepeat, oHeld} !== {eShort, eLong, eRepeat, eHeld}) begin
        failures++;
        $display("[TB] FAIL random_model: got %b expected %b", {oShort, oLong, oRepeat, oHeld}, {eShort, eLong, eRepeat, eHeld});
      end
      checks++;
      if ((int'(oShort) + int'(oLong) + int'(oRepeat)) > 1) begin
        failures++;
        $display("[TB] FAIL random_onehot: got %b expected at most one pulse", {oShort, oLong, oRepeat});
      end
    end
    randTick = 1'b0;
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_on_tick();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
Consumes the clean, debounced button level and classifies each press for the clock-setting UI. Emits one-cycle pulses: short press, long press, and auto-repeat while the button stays held after a long press. It sits between the debounce stage and the clock/mode FSM. Button hold time is measured in a shared 1 ms timebase tick, not in raw clocks.

Parameters:
LONG_MS, 1000, hold time in ms-ticks at which a press is classified as long (legal range >= 2).
REPEAT_MS, 200, period in ms-ticks between oRepeat pulses after oLong (legal range >= 1).
WIDTH, $clog2(LONG_MS+1), hold-counter width; it must cover both LONG_MS and REPEAT_MS.

Ports:
iClk  input  1  system clock; all logic is on the rising edge.
iRst  input  1  synchronous, active-low reset; sampled on the iClk rising edge.
iBtn_Level  input  1  debounced button level, high = pressed; synchronous to iClk.
iTick_1ms  input  1  one-cycle timebase pulse, one per ms.
oShort  output  1  one-cycle pulse: the press was released before reaching LONG_MS.
oLong  output  1  one-cycle pulse: the hold reached LONG_MS ticks.
oRepeat  output  1  one-cycle pulse every REPEAT_MS ticks after oLong while the button is still held.
oHeld  output  1  level; high while the FSM is in PRESS or HOLD.

Behaviour:
- Reset: the reset is synchronous, active-low and single-clock. With iRst=0 at a rising edge, the state goes to IDLE, the counter to 0, and oShort, oLong, oRepeat and oHeld all go to 0. Reset overrides everything, including during a hold: no pulse is emitted for a press that is cut off by reset.
- All outputs are registered. Each pulse is high for exactly one clock, in the cycle after the edge that decided it.
- States and transitions:
  - IDLE: if iBtn_Level=1, go to PRESS and clear the counter. Otherwise stay.
  - PRESS: if iBtn_Level=0, go to IDLE and set oShort=1. Otherwise, on iTick_1ms:
    - if counter==LONG_MS-1, go to HOLD, clear the counter, set oLong=1;
    - else increment the counter.
  - HOLD: if iBtn_Level=0, go to IDLE with no pulse. Otherwise, on iTick_1ms:
    - if counter==REPEAT_MS-1, clear the counter and set oRepeat=1;
    - else increment the counter.
- Ticks while in IDLE are ignored.
- Release and tick in the same cycle: release wins. The counter does not advance, and no oLong or oRepeat is emitted.
- A press as short as 1 clock (high for one sampled edge, low on the next) produces oShort.
- The first tick after entering PRESS counts as 1. oLong therefore fires on the LONG_MS-th tick after entry, so the actual hold time falls between LONG_MS-1 and LONG_MS ms.
- The counter never exceeds max(LONG_MS, REPEAT_MS)-1 and never wraps.
- An unbounded hold produces repeated oRepeat pulses indefinitely.
- oHeld=1 in the cycle after entering PRESS, and 0 in the cycle after returning to IDLE.
- At most one of oShort, oLong, oRepeat is high in any cycle.
- A re-press on the cycle immediately after a release returns to PRESS on the next edge. No dead time is inserted.

Test Plan:
- Setup for all scenarios: LONG_MS=4, REPEAT_MS=2, a tick every 10 clocks, and iRst held at 0 for 3 clocks, then 1. During reset, all outputs are 0.
- Short press: hold iBtn_Level high across 2 ticks, then release -> exactly one oShort pulse, one clock after the release edge; no oLong; oHeld falls with it.
- Long and repeat: hold across 9 ticks -> oLong at the 4th tick; oRepeat at the 6th and 8th ticks; no oRepeat at the 9th; release gives no oShort.
- Release coinciding with the 4th tick -> oShort=1 and oLong never asserts.
- Reset mid-hold: iRst=0 while in HOLD at tick 5 -> all outputs 0 on the next edge and no further pulses. With the button still high after reset, it re-enters PRESS and yields oLong 4 ticks later.
- Glitch and back-to-back: a 1-clock high pulse gives oShort. A second press starting the cycle right after that release gives a second, independent oShort.
